// File: rtl/apb_regfile_slave_if.sv
// apb_if: APB bus signals with requester (master) and completer (slave) views.
interface apb_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;
  modport master (output psel, penable, pwrite, paddr, pwdata, input prdata, pready, pslverr);
  modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/apb_regfile_slave.sv
// apb_regfile_slave: APB completer over a DEPTH-entry register bank with programmable wait states.
module apb_regfile_slave #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input logic  pclk,
  input logic  prst,
  apb_if.slave bus
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d, cmp_addr;
  logic              write_q, write_d, cmp_write, cmp_err;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic              ready_q, ready_d, err_q, err_d;
  logic              done, commit;
  logic [DATA_W-1:0] regs_q [DEPTH];
  assign bus.prdata  = rdata_q;
  assign bus.pready  = ready_q;
  assign bus.pslverr = err_q;
  // With no wait states the transfer completes on the setup edge, so the bus fields are used directly.
  assign cmp_addr  = state_q == IDLE ? bus.paddr : addr_q;
  assign cmp_write = state_q == IDLE ? bus.pwrite : write_q;
  assign cmp_err   = 32'(cmp_addr) >= DEPTH;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    done    = 1'b0;
    commit  = 1'b0;
    if (state_q == IDLE) begin
      if (bus.psel && !bus.penable) begin
        state_d = ACCESS;
        cnt_d   = 4'(WAIT_STATES);
        addr_d  = bus.paddr;
        write_d = bus.pwrite;
        wdata_d = bus.pwdata;
        done    = WAIT_STATES == 0;
      end
    end else if (ready_q) begin
      state_d = IDLE;
      commit  = bus.psel && bus.penable && write_q && !err_q;
    end else if (!bus.psel || !bus.penable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q - 4'd1;
      done  = cnt_q == 4'd1;
    end
    if (done) begin
      ready_d = 1'b1;
      err_d   = cmp_err;
      rdata_d = cmp_write ? rdata_q : cmp_err ? '0 : regs_q[cmp_addr[IW-1:0]];
    end
  end
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      if (commit) regs_q[addr_q[IW-1:0]] <= wdata_q;
    end
  end
endmodule

// File: tb/tb_apb_regfile_slave.sv
// tb_apb_regfile_slave: three completers (0, 2 and 3 wait states) checked against vectors and a register-array model.
module tb_apb_regfile_slave;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       psel [3], penable [3], pwrite [3], pready [3], pslverr [3];
  logic [7:0] paddr [3], pwdata [3], prdata [3];
  int         ws [3] = '{0, 2, 3};
  logic [7:0] mdl [3][16];
  int         tests = 0, fails = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : u
    apb_if #(.ADDR_W(8), .DATA_W(8)) bus ();
    apb_regfile_slave #(.ADDR_W(8), .DATA_W(8), .DEPTH(16), .WAIT_STATES(g == 0 ? 0 : g == 1 ? 2 : 3)) dut (
      .pclk(clk), .prst(rst), .bus(bus)
    );
    assign bus.psel    = psel[g];
    assign bus.penable = penable[g];
    assign bus.pwrite  = pwrite[g];
    assign bus.paddr   = paddr[g];
    assign bus.pwdata  = pwdata[g];
    assign prdata[g]   = bus.prdata;
    assign pready[g]   = bus.pready;
    assign pslverr[g]  = bus.pslverr;
  end
  typedef struct {
    int         d;
    bit         wr;
    logic [7:0] a, wd, rd;
    bit         err;
    int         lat;
  } vec_t;
  vec_t tbl [11];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  task automatic quiet_others(input int d);
    for (int i = 0; i < 3; i++) if (i != d) begin psel[i] = 1'b0; penable[i] = 1'b0; end
  endtask
  task automatic xfer(input int d, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                      output logic [7:0] rd, output logic er, output int lat);
    @(posedge clk); #1;
    quiet_others(d);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
    @(posedge clk); #1;
    penable[d] = 1'b1; paddr[d] = ~a; pwdata[d] = ~wd;
    lat = 1;
    while (!pready[d] && lat < 40) begin @(posedge clk); #1; lat++; end
    rd = prdata[d]; er = pslverr[d];
  endtask
  task automatic op(input int d, input bit wr, input logic [7:0] a, input logic [7:0] wd, input string nm);
    logic [7:0] rd;
    logic       er, xe;
    int         lat;
    xfer(d, wr, a, wd, rd, er, lat);
    xe = a >= 8'd16;
    chk({nm, " latency"}, lat, ws[d] + 1);
    chk({nm, " pslverr"}, er, xe);
    if (!wr) chk({nm, " prdata"}, rd, xe ? 8'h00 : mdl[d][a[3:0]]);
    if (wr && !xe) mdl[d][a[3:0]] = wd;
  endtask
  task automatic idle();
    @(posedge clk); #1;
    quiet_others(-1);
  endtask
  initial begin
    logic [7:0] rd;
    logic       er, seen;
    int         lat;
    for (int i = 0; i < 3; i++) begin
      psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0; paddr[i] = '0; pwdata[i] = '0;
      for (int j = 0; j < 16; j++) mdl[i][j] = '0;
    end
    tbl[0]  = '{0, 1'b1, 8'd3,  8'hA5, 8'h00, 1'b0, 1};
    tbl[1]  = '{0, 1'b0, 8'd3,  8'h00, 8'hA5, 1'b0, 1};
    tbl[2]  = '{1, 1'b1, 8'd7,  8'h3C, 8'h00, 1'b0, 3};
    tbl[3]  = '{1, 1'b0, 8'd7,  8'h00, 8'h3C, 1'b0, 3};
    tbl[4]  = '{0, 1'b1, 8'd16, 8'hFF, 8'h00, 1'b1, 1};
    tbl[5]  = '{0, 1'b0, 8'd16, 8'h00, 8'h00, 1'b1, 1};
    tbl[6]  = '{0, 1'b0, 8'd3,  8'h00, 8'hA5, 1'b0, 1};
    tbl[7]  = '{0, 1'b1, 8'd1,  8'h01, 8'h00, 1'b0, 1};
    tbl[8]  = '{0, 1'b1, 8'd2,  8'h02, 8'h00, 1'b0, 1};
    tbl[9]  = '{0, 1'b0, 8'd1,  8'h00, 8'h01, 1'b0, 1};
    tbl[10] = '{0, 1'b0, 8'd2,  8'h00, 8'h02, 1'b0, 1};
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset pready%0d", i), pready[i], 1'b0);
      chk($sformatf("reset pslverr%0d", i), pslverr[i], 1'b0);
      chk($sformatf("reset prdata%0d", i), prdata[i], 8'h00);
    end
    rst = 1'b0;
    for (int a = 0; a < 16; a++) op(0, 1'b0, 8'(a), 8'h00, $sformatf("reset read %0d", a));
    for (int i = 0; i < 11; i++) begin
      xfer(tbl[i].d, tbl[i].wr, tbl[i].a, tbl[i].wd, rd, er, lat);
      chk($sformatf("vec%0d latency", i), lat, tbl[i].lat);
      chk($sformatf("vec%0d pslverr", i), er, tbl[i].err);
      if (!tbl[i].wr) chk($sformatf("vec%0d prdata", i), rd, tbl[i].rd);
      if (tbl[i].wr && !tbl[i].err) mdl[tbl[i].d][tbl[i].a[3:0]] = tbl[i].wd;
    end
    for (int a = 0; a < 16; a++) op(0, 1'b0, 8'(a), 8'h00, $sformatf("sweep %0d", a));
    @(posedge clk); #1;
    quiet_others(2);
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 8'd2; pwdata[2] = 8'h11;
    @(posedge clk); #1;
    psel[2] = 1'b0;
    seen = pready[2];
    op(2, 1'b0, 8'd2, 8'h00, "abort then setup");
    idle();
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 8'd2; pwdata[2] = 8'h11;
    @(posedge clk); #1;
    psel[2] = 1'b0;
    repeat (6) begin seen |= pready[2]; @(posedge clk); #1; end
    chk("abort pready", seen, 1'b0);
    op(2, 1'b0, 8'd2, 8'h00, "abort reg2");
    idle();
    for (int n = 0; n < 90; n++) begin
      op($urandom_range(0, 2), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 19)), 8'($urandom),
         $sformatf("rand%0d", n));
      if ($urandom_range(0, 3) == 0) idle();
    end
    @(posedge clk); #1;
    quiet_others(1);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 8'd5; pwdata[1] = 8'h77;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("pre-reset pready", pready[1], 1'b1);
    rst = 1'b1;
    #1;
    chk("async reset pready", pready[1], 1'b0);
    psel[1] = 1'b0; penable[1] = 1'b0;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 16; j++) mdl[i][j] = '0;
    @(posedge clk); #2;
    rst = 1'b0;
    op(1, 1'b0, 8'd5, 8'h00, "post-reset reg5");
    op(1, 1'b0, 8'd7, 8'h00, "post-reset reg7");
    op(0, 1'b0, 8'd3, 8'h00, "post-reset dut0 reg3");
    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
